// File: rtl/pingpang_buffer.sv
// pingpang_buffer: two-bank ping-pong buffer for a DATA_W-bit sample stream.
// One bank is written from the input stream while the other is replayed
// to its registered output. The switch input selects which bank has which role.
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   data_en       - stream-advance strobe; qualifies both the write and the read
//   data_in_a/b   - write data for bank A (switch=0) / bank B (switch=1)
//   switch        - 0: write A, read B; 1: write B, read A
//   data_out_a/b  - registered read data from bank A / bank B
//   bank_full     - (PINGPANG_FULL_FLAG_EN only) write bank filled; writes blocked
//
// Optional feature macro: PINGPANG_FULL_FLAG_EN
//   When defined, bank_full is added and writes stop at DEPTH-1 instead of
//   wrapping. A bank swap clears the flag.
module pingpang_buffer #(
    parameter  int unsigned DATA_W = 16,
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_en,
    input  logic [DATA_W-1:0] data_in_a,
    input  logic [DATA_W-1:0] data_in_b,
    input  logic              switch,
    output logic [DATA_W-1:0] data_out_a,
    output logic [DATA_W-1:0] data_out_b
`ifdef PINGPANG_FULL_FLAG_EN
   ,output logic              bank_full
`endif
);

    // State registers and their next-state values
    logic [DATA_W-1:0] bank_a_q [DEPTH];
    logic [DATA_W-1:0] bank_a_d [DEPTH];
    logic [DATA_W-1:0] bank_b_q [DEPTH];
    logic [DATA_W-1:0] bank_b_d [DEPTH];
    logic [DATA_W-1:0] data_out_a_q, data_out_a_d;
    logic [DATA_W-1:0] data_out_b_q, data_out_b_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              switch_q, switch_d;
`ifdef PINGPANG_FULL_FLAG_EN
    logic              full_q, full_d;
    logic              full_eff_c;
`endif

    // Swap detection and effective addresses (a swap rewinds both pointers)
    logic              swap_c;
    logic              wr_en_c;
    logic [ADDR_W-1:0] eff_wr_c;
    logic [ADDR_W-1:0] eff_rd_c;

    always_comb begin
        swap_c   = (switch != switch_q);
        eff_wr_c = swap_c ? '0 : wr_ptr_q;
        eff_rd_c = swap_c ? '0 : rd_ptr_q;
`ifdef PINGPANG_FULL_FLAG_EN
        // The swap edge already sees the flag as cleared
        full_eff_c = swap_c ? 1'b0 : full_q;
        wr_en_c    = data_en && !full_eff_c;
`else
        wr_en_c    = data_en;
`endif
    end

    // Next-state logic: write the fill bank, read the replay bank
    always_comb begin
        bank_a_d     = bank_a_q;
        bank_b_d     = bank_b_q;
        data_out_a_d = data_out_a_q;
        data_out_b_d = data_out_b_q;
        wr_ptr_d     = eff_wr_c;
        rd_ptr_d     = eff_rd_c;
        switch_d     = switch;
`ifdef PINGPANG_FULL_FLAG_EN
        full_d       = full_eff_c;
`endif

        if (wr_en_c) begin
            if (!switch) begin
                bank_a_d[eff_wr_c] = data_in_a;
            end else begin
                bank_b_d[eff_wr_c] = data_in_b;
            end
            // Power-of-two depth: natural overflow wraps DEPTH-1 to 0
            wr_ptr_d = ADDR_W'(eff_wr_c + ADDR_W'(1));
`ifdef PINGPANG_FULL_FLAG_EN
            if (eff_wr_c == ADDR_W'(DEPTH - 1)) begin
                full_d = 1'b1;
            end
`endif
        end

        // Reads advance even while writes are blocked by the full flag
        if (data_en) begin
            if (!switch) begin
                data_out_b_d = bank_b_q[eff_rd_c];
                data_out_a_d = '0;
            end else begin
                data_out_a_d = bank_a_q[eff_rd_c];
                data_out_b_d = '0;
            end
            rd_ptr_d = ADDR_W'(eff_rd_c + ADDR_W'(1));
        end
    end

    // State register; banks are flops so they clear on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_a_q     <= '{default: '0};
            bank_b_q     <= '{default: '0};
            data_out_a_q <= '0;
            data_out_b_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            switch_q     <= 1'b0;
`ifdef PINGPANG_FULL_FLAG_EN
            full_q       <= 1'b0;
`endif
        end else begin
            bank_a_q     <= bank_a_d;
            bank_b_q     <= bank_b_d;
            data_out_a_q <= data_out_a_d;
            data_out_b_q <= data_out_b_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            switch_q     <= switch_d;
`ifdef PINGPANG_FULL_FLAG_EN
            full_q       <= full_d;
`endif
        end
    end

    assign data_out_a = data_out_a_q;
    assign data_out_b = data_out_b_q;
`ifdef PINGPANG_FULL_FLAG_EN
    assign bank_full  = full_q;
`endif

endmodule

// File: tb/tb_pingpang_buffer.sv
// tb_pingpang_buffer: table-driven bench for pingpang_buffer with an
// expected-value scoreboard queue.
module tb_pingpang_buffer;

    localparam int unsigned DW = 16;

    logic          clk;
    logic          rst_n;
    logic          data_en;
    logic [DW-1:0] data_in_a;
    logic [DW-1:0] data_in_b;
    logic          switch;
    logic [DW-1:0] data_out_a;
    logic [DW-1:0] data_out_b;
`ifdef PINGPANG_FULL_FLAG_EN
    logic          bank_full;
`endif

    pingpang_buffer #(.DATA_W(DW), .DEPTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_en    (data_en),
        .data_in_a  (data_in_a),
        .data_in_b  (data_in_b),
        .switch     (switch),
        .data_out_a (data_out_a),
        .data_out_b (data_out_b)
`ifdef PINGPANG_FULL_FLAG_EN
       ,.bank_full  (bank_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic          sw;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        logic          ef;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void add(input logic en, input logic sw,
                                input int a, input int b,
                                input int ea, input int eb, input logic ef);
        vec_t v;
        v.en = en; v.sw = sw;
        v.a  = DW'(a);  v.b  = DW'(b);
        v.ea = DW'(ea); v.eb = DW'(eb);
        v.ef = ef;
        vecs.push_back(v);
    endfunction

    function automatic void check(input string name, input int idx,
                                  input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endfunction

    task automatic check_outs(input int idx, input logic [DW-1:0] ea,
                              input logic [DW-1:0] eb, input logic ef);
        check("data_out_a", idx, data_out_a, ea);
        check("data_out_b", idx, data_out_b, eb);
`ifdef PINGPANG_FULL_FLAG_EN
        check("bank_full", idx, DW'(bank_full), DW'(ef));
`else
        if (ef) begin end
`endif
    endtask

    // Drive one vector, queue its expectation, compare after the edge
    task automatic step(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        data_en   = v.en;
        switch    = v.sw;
        data_in_a = v.a;
        data_in_b = v.b;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard vec %0d: queue empty", idx);
        end else begin
            e = sb.pop_front();
            check_outs(idx, e.ea, e.eb, e.ef);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   exp_rep;

        // Fill A with 1..10; B is empty so data_out_b reads 0
        for (int i = 1; i <= 10; i++) add(1, 0, i, 0, 0, 0, 0);
        // Swap to B: replay A from address 0, write B with 11..15
        for (int i = 0; i < 5; i++) add(1, 1, 0, 11 + i, 1 + i, 0, 0);
        // Swap back: replay B (11..15), rewrite A from 0 with 101..105
        for (int i = 0; i < 5; i++) add(1, 0, 101 + i, 0, 0, 11 + i, 0);
        // Stall: outputs hold
        for (int i = 0; i < 3; i++) add(0, 0, 999, 999, 0, 15, 0);
        // Resume at next address: B[5], B[6] are reset contents
        add(1, 0, 106, 0, 0, 0, 0);
        add(1, 0, 107, 0, 0, 0, 0);
        // Swap during a stall rewinds both pointers
        add(0, 1, 0, 999, 0, 0, 0);
        add(0, 1, 0, 999, 0, 0, 0);
        add(1, 1, 0, 200, 101, 0, 0);
        add(1, 1, 0, 201, 102, 0, 0);
        add(0, 1, 0, 999, 102, 0, 0);
        add(0, 1, 0, 999, 102, 0, 0);
        add(1, 1, 0, 202, 103, 0, 0);
        // Wrap: 20 writes into A; read B = 200,201,202,14,15,0.. cyclically
        for (int i = 0; i < 20; i++) begin
            int eb;
            case (i % 16)
                0: eb = 200;
                1: eb = 201;
                2: eb = 202;
                3: eb = 14;
                4: eb = 15;
                default: eb = 0;
            endcase
            add(1, 0, i + 1, 0, 0, eb, (i >= 15));
        end
        // Replay A after the wrap
        for (int j = 0; j < 16; j++) begin
`ifdef PINGPANG_FULL_FLAG_EN
            exp_rep = j + 1;
`else
            exp_rep = (j < 4) ? 17 + j : j + 1;
`endif
            add(1, 1, 0, 300 + j, exp_rep, 0, (j == 15));
        end

        // Reset with switch=0 and idle inputs
        rst_n = 1'b0; data_en = 1'b0; switch = 1'b0;
        data_in_a = '0; data_in_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outs(-1, 0, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

        // Asynchronous reset mid-stream while switch=1 and data_out_a is non-zero
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outs(1000, 0, 0, 1'b0);
        #2;
        data_en = 1'b0; switch = 1'b0;
        rst_n = 1'b1;
        // First edge after release: data_out_b reads the cleared B[0]
        v.en = 1; v.sw = 0; v.a = 16'd555; v.b = 0; v.ea = 0; v.eb = 0; v.ef = 0;
        step(v, 1001);
        // Swap to A: A[0]=555 just written, A[1] cleared by reset
        v.en = 1; v.sw = 1; v.a = 0; v.b = 16'd7; v.ea = 16'd555; v.eb = 0; v.ef = 0;
        step(v, 1002);
        v.en = 1; v.sw = 1; v.a = 0; v.b = 16'd8; v.ea = 0; v.eb = 0; v.ef = 0;
        step(v, 1003);

        if (sb.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard leftover: got %0d entries expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pingpang_buffer.md
Name: pingpang_buffer

Overview:
- Two-bank ping-pong buffer for a 16-bit sample stream from the upstream incrementing-counter source.
- While one bank is filled from the input, the other bank is replayed to its output.
- The `switch` input swaps the bank roles; the top level muxes the active output (`switch=1` uses `data_out_a`, `switch=0` uses `data_out_b`).

Parameters:
- DATA_W, 16, sample width of all data ports and bank words.
- DEPTH, 16, words per bank; power of two, at least 2.
- ADDR_W, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_en  in  1  stream-advance strobe; qualifies both the write and the read.
- data_in_a  in  DATA_W  write data for bank A; used only while switch=0.
- data_in_b  in  DATA_W  write data for bank B; used only while switch=1.
- switch  in  1  bank select. 0: write A, read B. 1: write B, read A.
- data_out_a  out  DATA_W  registered read data from bank A; valid while switch=1.
- data_out_b  out  DATA_W  registered read data from bank B; valid while switch=0.

Behaviour:
- **Reset (rst_n=0, async):**
  - data_out_a=0, data_out_b=0.
  - wr_ptr=0, rd_ptr=0, switch_q=0.
  - All words of both banks =0; banks are built from flops so they can be reset.
- **Role sampling:** bank roles are taken from `switch` as sampled at each rising edge.
- **Swap detect:** swap = (switch != switch_q); switch_q <= switch every cycle.
- **Effective address:** eff_wr = swap ? 0 : wr_ptr; eff_rd = swap ? 0 : rd_ptr.
- **Edge with data_en=1:**
  - Write bank[eff_wr] <= selected data_in (A when switch=0, B when switch=1).
  - Read output register <= read_bank[eff_rd] (B→data_out_b when switch=0, A→data_out_a when switch=1).
  - wr_ptr <= eff_wr+1 and rd_ptr <= eff_rd+1, modulo DEPTH (wraps DEPTH-1→0).
- **Edge with data_en=0:**
  - No write; both output registers hold.
  - Pointers <= eff_wr / eff_rd. A swap without data_en therefore still rewinds the pointers to 0.
- **Read latency:** 1 cycle; the word at address n appears on the output the edge after it is addressed.
- **Inactive output:** the output of the bank currently being written is cleared to 0 on the edge where data_en=1.
- **Same-bank collision:** a bank is never read and written in the same cycle, so there is no read/write hazard.
- **Overwrite:** with no swap, writing more than DEPTH words wraps and overwrites from address 0. The read side replays cyclically.
- **Reset mid-operation:** takes effect immediately (async). After release, operation resumes with switch_q=0; if switch=1 at the first edge, that edge is a swap.
- **Glitch free:** no combinational path from any input to any output.

Optional Feature:
- Macro: PINGPANG_FULL_FLAG_EN.
- **Defined:**
  - Adds output port `bank_full` (1 bit, reset 0).
  - `bank_full` sets on the edge that writes address DEPTH-1 and stays set.
  - While set, writes and wr_ptr advance are blocked (no overwrite); reads continue.
  - A swap clears it (cleared on the swap edge, same edge as the pointer rewind).
- **Undefined:** no `bank_full` port; writes wrap and overwrite as described above.

Test Plan:
- Reset: assert rst_n=0 mid-stream with switch=1 → data_out_a=0, data_out_b=0 immediately; after release with switch=0 and data_en=1, the first data_out_b=0.
- Fill A: switch=0, data_en=1, data_in_a=1..10 over 10 edges → A[0..9]=1..10; data_out_b stays 0; data_out_a stays 0.
- Swap to B: switch 0→1, data_en=1, data_in_b=11,12,... → data_out_a = 1,2,...,10 on consecutive edges (1-cycle latency); B[0]=11, B[1]=12, ...
- Swap back: switch 1→0 after 5 writes to B → data_out_b = 11..15 then 0 (reset contents); A is rewritten from address 0.
- Wrap: switch=0 held, 20 writes of 1..20 → A[0..3]=17..20, A[4..15]=5..16. With PINGPANG_FULL_FLAG_EN defined: A[0..15]=1..16, bank_full=1 after the 16th write, cleared by the next swap.
- Stall: drop data_en for 3 cycles mid-read → outputs and pointers hold, then resume with the next address; a swap during the stall rewinds both pointers to 0.
